// File: rtl/f1_reaction_timer.sv
// F1 reaction timer: watches the light sequence, times lights-out to button press,
// and flags jump starts and timeouts.
module f1_reaction_timer #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [7:0]       lights,
  input  logic             ms_tick,
  input  logic             btn,
  output logic [WIDTH-1:0] react_ms,
  output logic             valid,
  output logic             jump_start,
  output logic             timeout,
  output logic             busy
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SEQ    = 3'd1;
  localparam logic [2:0] ALL_ON = 3'd2;
  localparam logic [2:0] TIMING = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;
  localparam logic [2:0] JUMP   = 3'd5;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [2:0]             state, state_d;
  logic [WIDTH-1:0]       cnt, cnt_d, cnt_inc;
  logic [WIDTH-1:0]       react_d;
  logic                   valid_d, timeout_d, jump_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_prev;
  logic                   press;

  // Button synchronizer and rising-edge detect; runs regardless of en
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      btn_prev <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], btn};
      btn_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign press   = sync_q[SYNC_STAGES-1] & ~btn_prev;
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + WIDTH'(1);
  assign busy    = (state == SEQ) || (state == ALL_ON) || (state == TIMING);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      react_ms   <= '0;
      valid      <= 1'b0;
      timeout    <= 1'b0;
      jump_start <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      react_ms   <= react_d;
      valid      <= valid_d;
      timeout    <= timeout_d;
      jump_start <= jump_d;
    end
  end

  // Next-state and registered-output logic; en=0 holds everything
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    react_d   = react_ms;
    valid_d   = 1'b0;
    timeout_d = 1'b0;
    jump_d    = jump_start;
    if (en) begin
      case (state)
        IDLE: begin
          if (lights != 8'h00) begin
            state_d = SEQ;
            jump_d  = 1'b0;
          end
        end
        SEQ: begin
          if (press) begin
            state_d = JUMP;
            jump_d  = 1'b1;
          end else if (lights == 8'hFF) begin
            state_d = ALL_ON;
          end else if (lights == 8'h00) begin
            state_d = IDLE;
          end
        end
        ALL_ON: begin
          if (press) begin
            state_d = JUMP;
            jump_d  = 1'b1;
          end else if (lights == 8'h00) begin
            state_d = TIMING;
            cnt_d   = '0;
          end else if (lights != 8'hFF) begin
            state_d = SEQ;
          end
        end
        TIMING: begin
          if (ms_tick) cnt_d = cnt_inc;
          // A tick landing with the press counts toward the captured time
          if (press) begin
            state_d = DONE;
            react_d = ms_tick ? cnt_inc : cnt;
            valid_d = 1'b1;
          end else if (lights != 8'h00) begin
            state_d = SEQ;
          end else if (cnt == CNT_MAX) begin
            state_d   = IDLE;
            timeout_d = 1'b1;
          end
        end
        DONE: state_d = IDLE;
        JUMP: begin
          if (lights == 8'h00) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_f1_reaction_timer.sv
// Directed bench for f1_reaction_timer: a 16-bit instance plus a 4-bit instance
// sharing stimulus (the narrow one exercises counter saturation/timeout).
module tb_f1_reaction_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic [7:0]  lights = 8'h00;
  logic        ms_tick = 1'b0;
  logic        btn = 1'b0;

  logic [15:0] react16;
  logic        valid16, jump16, timeout16, busy16;
  logic [3:0]  react4;
  logic        valid4, jump4, timeout4, busy4;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  f1_reaction_timer #(.WIDTH(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .en(en), .lights(lights), .ms_tick(ms_tick), .btn(btn),
    .react_ms(react16), .valid(valid16), .jump_start(jump16), .timeout(timeout16), .busy(busy16)
  );

  f1_reaction_timer #(.WIDTH(4), .SYNC_STAGES(2)) dut4 (
    .clk(clk), .rst(rst), .en(en), .lights(lights), .ms_tick(ms_tick), .btn(btn),
    .react_ms(react4), .valid(valid4), .jump_start(jump4), .timeout(timeout4), .busy(busy4)
  );

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick();
    ms_tick = 1'b1;
    @(negedge clk);
    ms_tick = 1'b0;
    @(negedge clk);
  endtask

  // Lights 01,03,..,FF (4 clk each), then lights out; ends one edge into TIMING
  task automatic start_run();
    for (int i = 1; i <= 8; i++) begin
      lights = 8'((1 << i) - 1);
      wait_neg(4);
    end
    lights = 8'h00;
    wait_neg(1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_neg(2);
    checks++;
    if ({react16, valid16, jump16, timeout16, busy16} !== 20'h0) begin
      $display("FAIL reset16: got react=%0d v=%b j=%b t=%b b=%b, want all 0",
               react16, valid16, jump16, timeout16, busy16);
      fails++;
    end
    checks++;
    if ({react4, valid4, jump4, timeout4, busy4} !== 8'h0) begin
      $display("FAIL reset4: got react=%0d v=%b j=%b t=%b b=%b, want all 0",
               react4, valid4, jump4, timeout4, busy4);
      fails++;
    end
    rst = 1'b0;
    wait_neg(2);
  endtask

  task automatic test_normal();
    start_run();
    checks++;
    if (busy16 !== 1'b1) begin $display("FAIL timing_busy: got %b want 1", busy16); fails++; end
    repeat (5) tick();
    btn = 1'b1;
    wait_neg(3);
    checks++;
    if (valid16 !== 1'b1 || react16 !== 16'd5 || jump16 !== 1'b0) begin
      $display("FAIL normal_capture: got v=%b react=%0d j=%b, want v=1 react=5 j=0",
               valid16, react16, jump16);
      fails++;
    end
    wait_neg(1);
    checks++;
    if (valid16 !== 1'b0 || busy16 !== 1'b0 || react16 !== 16'd5) begin
      $display("FAIL valid_one_cycle: got v=%b b=%b react=%0d, want v=0 b=0 react=5",
               valid16, busy16, react16);
      fails++;
    end
    btn = 1'b0;
    wait_neg(4);
  endtask

  task automatic test_jump();
    for (int i = 1; i <= 4; i++) begin
      lights = 8'((1 << i) - 1);
      wait_neg(4);
    end
    btn = 1'b1;
    wait_neg(3);
    checks++;
    if (jump16 !== 1'b1 || valid16 !== 1'b0 || busy16 !== 1'b0) begin
      $display("FAIL jump_detect: got j=%b v=%b b=%b, want j=1 v=0 b=0", jump16, valid16, busy16);
      fails++;
    end
    btn = 1'b0;
    lights = 8'h00;
    wait_neg(2);
    checks++;
    if (jump16 !== 1'b1 || busy16 !== 1'b0) begin
      $display("FAIL jump_hold_idle: got j=%b b=%b, want j=1 b=0", jump16, busy16);
      fails++;
    end
    lights = 8'h01;
    wait_neg(1);
    checks++;
    if (jump16 !== 1'b0 || busy16 !== 1'b1) begin
      $display("FAIL jump_clear: got j=%b b=%b, want j=0 b=1", jump16, busy16);
      fails++;
    end
    lights = 8'h00;
    wait_neg(2);
  endtask

  task automatic test_timeout();
    start_run();
    repeat (15) tick();
    checks++;
    if (timeout4 !== 1'b1 || busy4 !== 1'b0 || react4 !== 4'd5 || valid4 !== 1'b0) begin
      $display("FAIL timeout_pulse: got t=%b b=%b react=%0d v=%b, want t=1 b=0 react=5 v=0",
               timeout4, busy4, react4, valid4);
      fails++;
    end
    checks++;
    if (busy16 !== 1'b1 || timeout16 !== 1'b0) begin
      $display("FAIL wide_still_timing: got b=%b t=%b, want b=1 t=0", busy16, timeout16);
      fails++;
    end
    wait_neg(1);
    checks++;
    if (timeout4 !== 1'b0) begin $display("FAIL timeout_one_cycle: got %b want 0", timeout4); fails++; end
    lights = 8'h01;
    wait_neg(1);
    checks++;
    if (valid16 !== 1'b0 || react16 !== 16'd5 || busy16 !== 1'b1) begin
      $display("FAIL restart_no_capture: got v=%b react=%0d b=%b, want v=0 react=5 b=1",
               valid16, react16, busy16);
      fails++;
    end
    lights = 8'h00;
    wait_neg(2);
  endtask

  task automatic test_tick_press();
    start_run();
    repeat (7) tick();
    btn = 1'b1;
    wait_neg(2);
    ms_tick = 1'b1;
    wait_neg(1);
    ms_tick = 1'b0;
    checks++;
    if (valid16 !== 1'b1 || react16 !== 16'd8) begin
      $display("FAIL tick_press16: got v=%b react=%0d, want v=1 react=8", valid16, react16);
      fails++;
    end
    checks++;
    if (valid4 !== 1'b1 || react4 !== 4'd8) begin
      $display("FAIL tick_press4: got v=%b react=%0d, want v=1 react=8", valid4, react4);
      fails++;
    end
    btn = 1'b0;
    wait_neg(4);
  endtask

  task automatic test_enable();
    start_run();
    repeat (3) tick();
    en = 1'b0;
    repeat (10) tick();
    btn = 1'b1;
    wait_neg(5);
    checks++;
    if (valid16 !== 1'b0 || busy16 !== 1'b1 || react16 !== 16'd8) begin
      $display("FAIL freeze_no_capture: got v=%b b=%b react=%0d, want v=0 b=1 react=8",
               valid16, busy16, react16);
      fails++;
    end
    btn = 1'b0;
    wait_neg(4);
    en = 1'b1;
    wait_neg(1);
    btn = 1'b1;
    wait_neg(3);
    checks++;
    if (valid16 !== 1'b1 || react16 !== 16'd3) begin
      $display("FAIL unfreeze_capture: got v=%b react=%0d, want v=1 react=3", valid16, react16);
      fails++;
    end
    btn = 1'b0;
    wait_neg(4);
  endtask

  task automatic test_reset_mid_run();
    logic saw_valid;
    logic saw_busy;
    start_run();
    repeat (4) tick();
    btn = 1'b1;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({react16, valid16, jump16, timeout16, busy16} !== 20'h0 || react4 !== 4'd0) begin
      $display("FAIL async_reset: got react=%0d v=%b j=%b t=%b b=%b react4=%0d, want all 0",
               react16, valid16, jump16, timeout16, busy16, react4);
      fails++;
    end
    wait_neg(2);
    rst = 1'b0;
    saw_valid = 1'b0;
    saw_busy  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wait_neg(1);
      saw_valid |= valid16;
      saw_busy  |= busy16;
    end
    checks++;
    if (saw_valid !== 1'b0 || saw_busy !== 1'b0 || react16 !== 16'd0) begin
      $display("FAIL held_btn_after_reset: got valid_seen=%b busy_seen=%b react=%0d, want 0 0 0",
               saw_valid, saw_busy, react16);
      fails++;
    end
    btn = 1'b0;
    wait_neg(2);
  endtask

  initial begin
    test_reset();
    test_normal();
    test_jump();
    test_timeout();
    test_tick_press();
    test_enable();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
